ram_boot_loader: RTL
====================

RAM_BOOT_LOADER -- requirements
Module: ram_boot_loader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 9, RAM address width in bits.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, RAM word width in bits.
REQ-003 The block SHALL have parameter BASE_ADDR, default 0, first RAM address written; DEPTH = 2**ADDR_WIDTH - BASE_ADDR.
REQ-004 The block SHALL have parameter ZERO_FILL, default 0; 1 = zero-fill from the word after the image to the top of RAM.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, named main_clk and reset as elsewhere in the codebase.
REQ-006 Port main_clk, input, 1, system clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1, asynchronous active-low reset.
REQ-008 Port start, input, 1, begin a load; sampled in IDLE, DONE and ERROR only.
REQ-009 Port in_valid, input, 1, in_data/in_last valid.
REQ-010 Port in_data, input, DATA_WIDTH, image word.
REQ-011 Port in_last, input, 1, current word is the final image word.
REQ-012 Port in_ready, output, 1, loader accepts a word this cycle.
REQ-013 Port mem_we, output, 1, RAM write strobe.
REQ-014 Port mem_addr, output, ADDR_WIDTH, RAM write address.
REQ-015 Port mem_wdata, output, DATA_WIDTH, RAM write data.
REQ-016 Port cpu_hold, output, 1, holds the core in reset while high.
REQ-017 Port done, output, 1, image loaded.
REQ-018 Port error, output, 1, image overflowed RAM.
REQ-019 Port byte_count, output, ADDR_WIDTH+1, words accepted in the current load.
REQ-020 Port checksum, output, DATA_WIDTH, sum of accepted words mod 2**DATA_WIDTH.

Function
REQ-021 The FSM SHALL have states IDLE, LOAD, FILL, DONE and ERROR.
REQ-022 In IDLE, DONE or ERROR, start=1 SHALL move to LOAD on the next edge and clear byte_count, checksum, done and error; cpu_hold SHALL be 1.
REQ-023 start SHALL be ignored in LOAD and FILL.
REQ-024 in_ready SHALL be 1 only in LOAD; a transfer occurs on an edge where in_valid and in_ready are both 1.
REQ-025 A transfer SHALL, in the following cycle, drive mem_we=1 for exactly one cycle with mem_addr = BASE_ADDR + old byte_count and mem_wdata = in_data (one-cycle registered latency).
REQ-026 A transfer SHALL increment byte_count by 1 and add in_data to checksum, discarding the carry.
REQ-027 Cycles without a transfer SHALL produce no write and SHALL leave byte_count and checksum unchanged.
REQ-028 A transfer with in_last=1 SHALL go to FILL when ZERO_FILL=1 and the written address is below 2**ADDR_WIDTH-1; otherwise it SHALL go to DONE.
REQ-029 A transfer when byte_count == DEPTH SHALL go to ERROR and SHALL NOT write; a DEPTH-th word with in_last=1 is legal and SHALL go to DONE or FILL.
REQ-030 FILL SHALL write 0 to each successive address, one per cycle, up to and including 2**ADDR_WIDTH-1, then go to DONE; byte_count and checksum SHALL be unchanged.
REQ-031 DONE SHALL drive done=1, cpu_hold=0 and in_ready=0 until start or reset.
REQ-032 ERROR SHALL drive error=1, cpu_hold=1 and in_ready=0 until start or reset.
REQ-033 mem_we SHALL be 0 in IDLE, DONE and ERROR, except the single trailing write of the last accepted word.

Reset
REQ-034 Asserting reset low SHALL, without waiting for a clock edge, force IDLE, in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1, done=0, error=0, byte_count=0 and checksum=0.
REQ-035 Reset during LOAD or FILL SHALL abort the load without undoing RAM writes already issued; the next load SHALL restart at BASE_ADDR.

Verification (ADDR_WIDTH=4, DATA_WIDTH=8, BASE_ADDR=0)
REQ-036 ZERO_FILL=0: start, then 0x11, 0x22, 0x33 (in_last on the third) -> writes at addresses 0, 1, 2; byte_count=3; checksum=0x66; done=1; cpu_hold=0.
REQ-037 ZERO_FILL=1: 0xFF, 0x01 with in_last -> checksum=0x00 (wrap); 14 zero writes at addresses 2..15; then done=1.
REQ-038 Overflow: 16 words without in_last, then a 17th word -> exactly 16 writes; error=1; cpu_hold=1; done=0.
REQ-039 in_valid pattern 1,0,0,1,1,0,1 with 0x01..0x04, last on the fourth -> exactly 4 writes at addresses 0..3; byte_count=4; checksum=0x0A.
REQ-040 reset low between clock edges after 5 words -> all outputs at reset values immediately; a new start loads from address 0.
REQ-041 start pulse in DONE -> done=0 and cpu_hold=1 on the next edge; a new image loads from address 0.

Source files
------------

// File: rtl/ram_boot_loader.sv
// ram_boot_loader: streams a boot image into RAM while holding the core in
// reset. Optionally zero-fills the rest of RAM, then releases the core.
// An image longer than the RAM window parks the block in ERROR.
module ram_boot_loader #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int BASE_ADDR  = 0,
    parameter int ZERO_FILL  = 0
) (
    input  logic                  main_clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   byte_count,
    output logic [DATA_WIDTH-1:0] checksum
);

    // Number of words that fit between BASE_ADDR and the top of RAM.
    localparam logic [ADDR_WIDTH:0]   DEPTH = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] TOP   = '1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FILL  = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   byte_count_q, byte_count_d;
    logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  in_ready_q, in_ready_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  xfer;

    assign wr_addr = BASE + byte_count_q[ADDR_WIDTH-1:0];
    assign xfer    = in_valid && (state_q == LOAD);

    // Next-state, counters and the registered write port.
    always_comb begin
        state_d      = state_q;
        byte_count_d = byte_count_q;
        checksum_d   = checksum_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d      = LOAD;
                    byte_count_d = '0;
                    checksum_d   = '0;
                end
            end
            LOAD: begin
                if (xfer) begin
                    if (byte_count_q == DEPTH) begin
                        // RAM already full: reject the word without writing.
                        state_d = ERROR;
                    end else begin
                        mem_we_d     = 1'b1;
                        mem_addr_d   = wr_addr;
                        mem_wdata_d  = in_data;
                        byte_count_d = byte_count_q + (ADDR_WIDTH+1)'(1);
                        checksum_d   = checksum_q + in_data;
                        if (in_last)
                            state_d = (ZERO_FILL != 0 && wr_addr != TOP) ? FILL : DONE;
                    end
                end
            end
            FILL: begin
                // mem_addr_q is the address being written this cycle; stay in
                // FILL until the write to the top address has been presented.
                if (mem_addr_q == TOP) begin
                    state_d = DONE;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = mem_addr_q + ADDR_WIDTH'(1);
                    mem_wdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are registered from the state being entered.
    always_comb begin
        in_ready_d = (state_d == LOAD);
        cpu_hold_d = (state_d != DONE);
        done_d     = (state_d == DONE);
        error_d    = (state_d == ERROR);
    end

    // Single state register for the FSM and all registered outputs.
    always_ff @(posedge main_clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            byte_count_q <= '0;
            checksum_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= BASE;
            mem_wdata_q  <= '0;
            in_ready_q   <= 1'b0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_count_q <= byte_count_d;
            checksum_q   <= checksum_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            in_ready_q   <= in_ready_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign error      = error_q;
    assign byte_count = byte_count_q;
    assign checksum   = checksum_q;

endmodule
